// File: rtl/clock_phase_sequencer_pkg.sv
// rtl/clock_phase_sequencer_pkg.sv - shared state encodings and defaults for the phase sequencer
package clock_phase_sequencer_pkg;

    localparam int NPHASE_DEF = 4;
    localparam int DIVW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/phase_div_counter.sv
// rtl/phase_div_counter.sv - loadable per-phase down-counter with terminal-count flags
module phase_div_counter
    import clock_phase_sequencer_pkg::*;
#(
    parameter int DIVW = DIVW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    input  logic            dec,
    output logic            tc,
    output logic            tc_next
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tc_next lets the parent register a pulse that lines up with the clock where tc is true
    assign tc      = (cnt_q == '0);
    assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/clock_phase_sequencer.sv
// rtl/clock_phase_sequencer.sv - one-hot phase-enable sequencer with run/halt and single-step control
module clock_phase_sequencer
    import clock_phase_sequencer_pkg::*;
#(
    parameter int NPHASE = NPHASE_DEF,
    parameter int DIVW   = DIVW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIVW-1:0]           div_cfg,
    input  logic                      run,
    input  logic                      step_req,
    output logic                      step_ack,
    output logic [NPHASE-1:0]         phase_en,
    output logic [$clog2(NPHASE)-1:0] phase_idx,
    output logic                      cycle_done,
    output logic                      busy,
    output logic                      halted
);

    localparam int IW = $clog2(NPHASE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPHASE - 1);

    seq_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NPHASE-1:0] phase_en_q, phase_en_d;
    logic              cycle_done_q, cycle_done_d;
    logic              step_ack_q, step_ack_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              run_q, run_d;
    logic              step_q, step_d;
    logic              step_prev_q, step_prev_d;

    logic              enter;
    logic              cnt_dec;
    logic              cnt_tc;
    logic              cnt_tc_next;
    logic              step_rise;

    phase_div_counter #(.DIVW(DIVW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (enter),
        .load_val (div_cfg),
        .dec      (cnt_dec),
        .tc       (cnt_tc),
        .tc_next  (cnt_tc_next)
    );

    // run and step_req are registered once; the step request is qualified on its rising edge
    assign run_d       = run;
    assign step_d      = step_req;
    assign step_prev_d = step_q;
    assign step_rise   = step_q & ~step_prev_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        enter   = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            ST_HALT: begin
                idx_d = '0;
                if (run_q) begin
                    state_d = ST_RUN;
                    enter   = 1'b1;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                    enter   = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (!cnt_tc) begin
                    cnt_dec = 1'b1;
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                    enter = 1'b1;
                end else begin
                    idx_d = '0;
                    if ((state_q == ST_RUN) && run_q) begin
                        enter = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
                idx_d   = '0;
            end
        endcase
    end

    // Output pulses are computed one clock early so the registered copies land on the right clock
    always_comb begin
        phase_en_d   = enter ? ({{(NPHASE-1){1'b0}}, 1'b1} << idx_d) : '0;
        busy_d       = (state_d != ST_HALT);
        halted_d     = ~busy_d;
        cycle_done_d = busy_d && (idx_d == LAST_IDX) && cnt_tc_next;
        step_ack_d   = cycle_done_d && (state_d == ST_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HALT;
            idx_q        <= '0;
            phase_en_q   <= '0;
            cycle_done_q <= 1'b0;
            step_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b1;
            run_q        <= 1'b0;
            step_q       <= 1'b0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            phase_en_q   <= phase_en_d;
            cycle_done_q <= cycle_done_d;
            step_ack_q   <= step_ack_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            run_q        <= run_d;
            step_q       <= step_d;
            step_prev_q  <= step_prev_d;
        end
    end

    assign phase_en   = phase_en_q;
    assign phase_idx  = idx_q;
    assign cycle_done = cycle_done_q;
    assign step_ack   = step_ack_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// tb/tb_clock_phase_sequencer.sv - scoreboard bench for clock_phase_sequencer
module tb_clock_phase_sequencer;

    localparam int NP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] div_cfg = '0;
    logic          run = 1'b0;
    logic          step_req = 1'b0;
    logic          step_ack;
    logic [NP-1:0] phase_en;
    logic [1:0]    phase_idx;
    logic          cycle_done;
    logic          busy;
    logic          halted;

    clock_phase_sequencer #(.NPHASE(NP), .DIVW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_cfg    (div_cfg),
        .run        (run),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .phase_en   (phase_en),
        .phase_idx  (phase_idx),
        .cycle_done (cycle_done),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pe;
        logic [1:0] idx;
        logic       cd;
        logic       ack;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if ((phase_en != '0) || cycle_done || step_ack) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_event cyc=%0d got pe=%b idx=%0d cd=%b ack=%b expected no event",
                         cyc, phase_en, phase_idx, cycle_done, step_ack);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.pe !== phase_en) || (e.idx !== phase_idx) ||
                    (e.cd !== cycle_done) || (e.ack !== step_ack)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL event: got cyc=%0d pe=%b idx=%0d cd=%b ack=%b expected cyc=%0d pe=%b idx=%0d cd=%b ack=%b",
                             cyc, phase_en, phase_idx, cycle_done, step_ack,
                             e.cyc, e.pe, e.idx, e.cd, e.ack);
                end
            end
        end
    end

    task automatic push_cycle(input int s, input int d, input bit ack, input int nph);
        ev_t e;
        for (int p = 0; p < nph; p++) begin
            e.cyc = s + p * (d + 1);
            e.pe  = 4'b0001 << p;
            e.idx = p[1:0];
            e.cd  = (p == 3) && (d == 0);
            e.ack = e.cd && ack;
            exp_q.push_back(e);
        end
        if ((nph == 4) && (d > 0)) begin
            e.cyc = s + 4 * (d + 1) - 1;
            e.pe  = 4'b0000;
            e.idx = 2'd3;
            e.cd  = 1'b1;
            e.ack = ack;
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        if (act !== expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0) && (t < 300)) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k, s;

        // 1: reset, then idle in HALT
        rst = 1'b1;
        tick(3);
        check("rst_halted", halted, 1);
        check("rst_busy", busy, 0);
        check("rst_phase_en", phase_en, 0);
        check("rst_phase_idx", phase_idx, 0);
        check("rst_cycle_done", cycle_done, 0);
        check("rst_step_ack", step_ack, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_halted", halted, 1);
            check("idle_busy", busy, 0);
            check("idle_phase_en", phase_en, 0);
        end

        // 2: div_cfg=2 free-run, three back-to-back cycles
        k = cyc;
        div_cfg = 8'd2;
        run = 1'b1;
        s = k + 2;
        push_cycle(s, 2, 1'b0, 4);
        push_cycle(s + 12, 2, 1'b0, 4);
        push_cycle(s + 24, 2, 1'b0, 4);
        tick(2 + 28);
        run = 1'b0;
        tick(7);
        check("run_busy_last_clk", busy, 1);
        tick(1);
        check("run_halted_after", halted, 1);
        drain();

        // 3: div_cfg=0, run dropped during phase 1 still completes the cycle
        k = cyc;
        div_cfg = 8'd0;
        run = 1'b1;
        push_cycle(k + 2, 0, 1'b0, 4);
        tick(3);
        check("drop_in_phase1_idx", phase_idx, 1);
        run = 1'b0;
        tick(3);
        check("drop_halted_after", halted, 1);
        check("drop_idx_zero", phase_idx, 0);
        drain();

        // 4: step_req held high gives exactly one step; re-arm after low
        tick(2);
        k = cyc;
        div_cfg = 8'd1;
        step_req = 1'b1;
        push_cycle(k + 2, 1, 1'b1, 4);
        tick(20);
        check("step_held_halted", halted, 1);
        step_req = 1'b0;
        tick(2);
        k = cyc;
        step_req = 1'b1;
        push_cycle(k + 2, 1, 1'b1, 4);
        tick(3);
        step_req = 1'b0;
        drain();
        tick(2);
        check("step2_halted", halted, 1);

        // 5: run and step_req together enter RUN without ack
        k = cyc;
        div_cfg = 8'd0;
        run = 1'b1;
        step_req = 1'b1;
        push_cycle(k + 2, 0, 1'b0, 4);
        tick(2);
        run = 1'b0;
        step_req = 1'b0;
        check("both_busy", busy, 1);
        tick(4);
        check("both_halted", halted, 1);
        drain();

        // 6: reset during phase 2 aborts the cycle silently
        k = cyc;
        div_cfg = 8'd3;
        run = 1'b1;
        s = k + 2;
        push_cycle(s, 3, 1'b0, 3);
        tick(2 + 9);
        check("abort_in_phase2", phase_idx, 2);
        rst = 1'b1;
        run = 1'b0;
        tick(1);
        check("abort_phase_en", phase_en, 0);
        check("abort_phase_idx", phase_idx, 0);
        check("abort_cycle_done", cycle_done, 0);
        check("abort_step_ack", step_ack, 0);
        check("abort_busy", busy, 0);
        check("abort_halted", halted, 1);
        rst = 1'b0;
        tick(20);
        check("abort_stays_halted", halted, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
